// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read side of a byte FIFO
// master pops, slave presents the head byte
interface fifo_uart_tx_if;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_read;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_read
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    input  fifo_read
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO into UART frames
// start, 8 data LSB-first, optional parity, one stop
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_uart_tx_if.master fifo,
  input  logic           enable,
  output logic           txd,
  output logic           busy,
  output logic           tx_done
);
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          bit_end;
  logic          can_go;
  logic          launch;

  assign bit_end = (cnt == CMAX);
  assign can_go  = enable & ~fifo.fifo_empty;

  // rst_n gate keeps the pop strobe quiet while held in reset
  always_comb begin
    launch = 1'b0;
    unique case (1'b1)
      state == IDLE: launch = can_go;
      state == STOP: launch = can_go & bit_end;
      default:       launch = 1'b0;
    endcase
    launch = launch & rst_n;
  end

  assign fifo.fifo_read = launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bidx    <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      // done lands on the stop bit's final cycle
      tx_done <= (state == STOP) &&
                 (cnt == CMAX - 1'b1);
      if (launch) begin
        state   <= START;
        cnt     <= '0;
        shreg   <= fifo.fifo_dout;
        par_bit <= (PARITY == 2) ?
                   ~^fifo.fifo_dout :
                   ^fifo.fifo_dout;
        txd     <= 1'b0;
        busy    <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            cnt  <= '0;
            txd  <= 1'b1;
            busy <= 1'b0;
          end
          START: begin
            if (bit_end) begin
              state <= DATA;
              cnt   <= '0;
              bidx  <= '0;
              txd   <= shreg[0];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              cnt <= '0;
              if (bidx == 3'd7) begin
                if (PARITY != 0) begin
                  state <= PAR;
                  txd   <= par_bit;
                end else begin
                  state <= STOP;
                  txd   <= 1'b1;
                end
              end else begin
                bidx  <= bidx + 3'd1;
                shreg <= shreg >> 1;
                txd   <= shreg[1];
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PAR: begin
            if (bit_end) begin
              state <= STOP;
              cnt   <= '0;
              txd   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            txd <= 1'b1;
            if (bit_end) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: frame-level model plus directed checks
// u0 no parity, u1 even, u2 odd; all at 4 clocks/bit
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] en    = 3'b001;
  logic [2:0] txd;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] rd;
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [3][64];
  logic [5:0]  wp  [3] = '{6'd0, 6'd0, 6'd0};
  logic [5:0]  rp  [3] = '{6'd0, 6'd0, 6'd0};
  logic [5:0]  mp  [3] = '{6'd0, 6'd0, 6'd0};
  logic        act [3] = '{1'b0, 1'b0, 1'b0};
  int          pos [3] = '{0, 0, 0};
  logic [10:0] frm [3] = '{11'h7ff, 11'h7ff, 11'h7ff};

  always #5 clk = ~clk;

  fifo_uart_tx_if f0 ();
  fifo_uart_tx_if f1 ();
  fifo_uart_tx_if f2 ();

  assign rd = {f2.fifo_read, f1.fifo_read, f0.fifo_read};
  assign f0.fifo_dout  = mem[0][rp[0]];
  assign f1.fifo_dout  = mem[1][rp[1]];
  assign f2.fifo_dout  = mem[2][rp[2]];
  assign f0.fifo_empty = (rp[0] == wp[0]);
  assign f1.fifo_empty = (rp[1] == wp[1]);
  assign f2.fifo_empty = (rp[2] == wp[2]);

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .fifo(f0), .enable(en[0]),
    .txd(txd[0]), .busy(busy[0]), .tx_done(done[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .fifo(f1), .enable(en[1]),
    .txd(txd[1]), .busy(busy[1]), .tx_done(done[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .fifo(f2), .enable(en[2]),
    .txd(txd[2]), .busy(busy[2]), .tx_done(done[2]));

  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (rd[i]) rp[i] <= rp[i] + 6'd1;

  function automatic int flen(int i);
    return (i == 0) ? 10 * CPB : 11 * CPB;
  endfunction

  function automatic logic mlaunch(int i);
    return rst_n && en[i] && (mp[i] != wp[i]) &&
           (!act[i] || pos[i] == flen(i) - 1);
  endfunction

  function automatic logic [10:0] mkframe(int i, logic [7:0] b);
    logic p;
    p = ^b;
    if (i == 2) p = ~p;
    if (i == 0) return {2'b11, b, 1'b0};
    return {1'b1, p, b, 1'b0};
  endfunction

  // model: a frame is a bit vector played for flen cycles after the pop
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        act[i] <= 1'b0;
      end else if (mlaunch(i)) begin
        frm[i] <= mkframe(i, mem[i][mp[i]]);
        mp[i]  <= mp[i] + 6'd1;
        act[i] <= 1'b1;
        pos[i] <= 0;
      end else if (act[i]) begin
        if (pos[i] == flen(i) - 1) act[i] <= 1'b0;
        else pos[i] <= pos[i] + 1;
      end
    end

  task automatic chk(string nm, int i, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] got %0b want %0b t=%0t",
               nm, i, a, e, $time);
    end
  endtask

  task automatic chkv(string nm, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d t=%0t",
               nm, a, e, $time);
    end
  endtask

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      chk("txd", i, txd[i],
          (rst_n && act[i]) ? frm[i][pos[i] / CPB] : 1'b1);
      chk("busy", i, busy[i], rst_n && act[i]);
      chk("done", i, done[i],
          rst_n && act[i] && pos[i] == flen(i) - 1);
      chk("read", i, rd[i], mlaunch(i));
    end

  task automatic push(int i, logic [7:0] b);
    mem[i][wp[i]] = b;
    wp[i] = wp[i] + 6'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read(int i);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rd[i]) return;
    end
    chkv("read_timeout", 0, 1);
  endtask

  initial begin
    logic [9:0] v;
    int dat, bz, nr, t1, t2, d1, d2;
    logic p1, p2;

    // reset held with data waiting
    push(0, 8'h11);
    repeat (3) @(negedge clk);
    chkv("rst_txd", txd[0], 1);
    chkv("rst_busy", busy[0], 0);
    chkv("rst_done", done[0], 0);
    chkv("rst_read", rd[0], 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chkv("rst_pop", rd[0], 1);
    repeat (50) @(negedge clk);

    // single byte 0xA5
    step();
    push(0, 8'ha5);
    wait_read(0);
    v = '0; dat = 0; bz = 0; nr = 0;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (c % 4 == 2 && c / 4 < 10) v[c / 4] = txd[0];
      if (done[0] && dat == 0) dat = c;
      bz += int'(busy[0]);
      nr += int'(rd[0]);
    end
    chkv("a5_bits", int'(v), int'(10'b1101001010));
    chkv("a5_done", dat, 40);
    chkv("a5_busy", bz, 40);
    chkv("a5_pops", nr, 0);

    // back-to-back
    step();
    push(0, 8'h00);
    push(0, 8'hff);
    push(0, 8'h55);
    wait_read(0);
    bz = 0; nr = 0; t1 = 0; t2 = 0;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      bz += int'(busy[0]);
      if (rd[0]) begin
        nr++;
        if (nr == 1) t1 = c;
        if (nr == 2) t2 = c;
      end
    end
    chkv("b2b_gap1", t1, 40);
    chkv("b2b_gap2", t2, 80);
    chkv("b2b_pops", nr, 2);
    chkv("b2b_busy", bz, 120);
    chkv("b2b_empty", f0.fifo_empty, 1);

    // parity even / odd on 0x07
    step();
    push(1, 8'h07);
    push(2, 8'h07);
    en[2:1] = 2'b11;
    wait_read(1);
    chkv("par_sync", rd[2], 1);
    p1 = 1'b0; p2 = 1'b1; d1 = 0; d2 = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 38) begin
        p1 = txd[1];
        p2 = txd[2];
      end
      if (done[1] && d1 == 0) d1 = c;
      if (done[2] && d2 == 0) d2 = c;
    end
    chkv("par_even", p1, 1);
    chkv("par_odd", p2, 0);
    chkv("par_len1", d1, 44);
    chkv("par_len2", d2, 44);
    step();
    en[2:1] = 2'b00;

    // enable gating
    en[0] = 1'b0;
    push(0, 8'h3c);
    push(0, 8'h99);
    nr = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      nr += int'(rd[0]);
    end
    chkv("en_hold", nr, 0);
    step();
    en[0] = 1'b1;
    wait_read(0);
    chkv("en_byte", f0.fifo_dout, 8'h3c);
    repeat (20) @(negedge clk);
    step();
    en[0] = 1'b0;
    nr = 0; dat = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      nr += int'(rd[0]);
      dat += int'(done[0]);
    end
    chkv("en_nopop", nr, 0);
    chkv("en_finish", dat, 1);

    // reset during data bit 3
    push(0, 8'h42);
    step();
    en[0] = 1'b1;
    wait_read(0);
    chkv("mid_byte", f0.fifo_dout, 8'h99);
    repeat (17) @(negedge clk);
    step();
    rst_n = 1'b0;
    #1;
    chkv("mid_txd", txd[0], 1);
    chkv("mid_busy", busy[0], 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_read(0);
    chkv("mid_next", f0.fifo_dout, 8'h42);
    repeat (50) @(negedge clk);
    chkv("mid_empty", f0.fifo_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains a byte FIFO from its read side and shifts each byte out as an asynchronous UART frame: start bit, 8 data bits LSB-first, optional parity, one stop bit. It connects to the FIFO's `dout`/`empty`/`read` ports and sends the LC-3 system's outbound character stream to the serial pin. It pops at most one byte per frame and sends consecutive bytes with no idle gap while data is available.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are ≥ 2.
- `PARITY`, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `fifo_dout`, input, 8: FIFO head byte. Valid whenever `fifo_empty` = 0.
- `fifo_empty`, input, 1: FIFO empty flag.
- `fifo_read`, output, 1: pop strobe to the FIFO, one cycle wide.
- `enable`, input, 1: when high, the block may start new frames.
- `txd`, output, 1: serial line. Idles high.
- `busy`, output, 1: high while a frame is in progress.
- `tx_done`, output, 1: one-cycle pulse in the last cycle of each stop bit.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - PAR (entered only when `PARITY` ≠ 0)
  - STOP
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 within each bit and clears on every state or bit change. A "bit end" is counter = CLKS_PER_BIT-1.
- Bit index: 3 bits, used in DATA only.
- Launch condition: `enable` & ~`fifo_empty`, evaluated in IDLE, or in STOP at bit end.
- `fifo_read` is a combinational decode of the registered state, the counter and the launch condition. It is never asserted at any other time.
- On a launch, in the same edge:
  - `fifo_dout` is captured into the shift register.
  - Parity is computed from the captured byte: even mode = XOR of the bits; odd mode = its inverse.
  - The state goes to START and the counter clears.
- Transitions:
  - START → DATA at bit end.
  - DATA shifts right at each bit end. After bit index 7 it goes to PAR, or to STOP if `PARITY` = 0.
  - PAR → STOP at bit end.
  - STOP at bit end goes to START if the launch condition holds (back-to-back frame), otherwise to IDLE.
- `txd` is registered:
  - 1 in IDLE and STOP.
  - 0 in START.
  - Shift register bit 0 in DATA.
  - The parity bit in PAR.
- `busy` = (state ≠ IDLE).
- `tx_done` = (state = STOP) & bit end.
- `enable` low blocks launches only. A frame already in progress always completes.
- FIFO empty during a frame has no effect. The block never pops with `fifo_empty` = 1.

## Timing
- Reset values, applied asynchronously:
  - state = IDLE
  - `txd` = 1
  - `fifo_read` = 0
  - `busy` = 0
  - `tx_done` = 0
  - counter, bit index and shift register = 0
- Launch cycle N (`fifo_read` = 1): `txd` falls at the edge ending cycle N. `busy` rises at the same edge.
- Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- Frame length F = (10 + (PARITY≠0)) × CLKS_PER_BIT cycles, measured from the falling edge of `txd`.
- `tx_done` is high in cycle N+F.
- For a back-to-back frame, `fifo_read` pulses in that same cycle N+F and `txd` goes low at the next edge, so there is no idle cycle between frames. Consecutive `fifo_read` pulses are exactly F cycles apart.
- Without a back-to-back frame, `busy` falls after cycle N+F. The earliest next launch is cycle N+F+1.
- Reset asserted mid-frame:
  - `txd` returns to 1 immediately.
  - The byte already popped is discarded.
  - No `fifo_read` occurs until `rst_n` is high and the launch condition is met in IDLE.
- Pop-then-empty: after a pop that empties the FIFO, its `fifo_empty` is registered and may lag by one cycle. The block does not sample `fifo_empty` again until the next STOP bit end, so it cannot double-pop.

## Test plan
- Reset: hold `rst_n` = 0 with a non-empty FIFO. Expect `txd` = 1, `fifo_read` = 0, `busy` = 0, `tx_done` = 0. Release: a launch occurs in the first IDLE cycle.
- Single byte: CLKS_PER_BIT = 4, PARITY = 0, push 0xA5.
  - Expect exactly one `fifo_read` pulse.
  - `txd` = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `tx_done` at cycle 40 after the pop.
  - `busy` high for 40 cycles, then IDLE.
- Back-to-back: preload 0x00, 0xFF, 0x55.
  - Expect 3 pops spaced exactly 40 cycles apart.
  - 30 continuous bit times with no idle-high gap between stop and start.
  - FIFO empty at the end and no fourth pop.
- Parity: send 0x07 with PARITY = 1, then with PARITY = 2.
  - Expect parity bit 1, then 0.
  - 11-bit frames, 44 cycles at CLKS_PER_BIT = 4.
- Enable:
  - `enable` = 0 with the FIFO holding 0x3C: no pop for 100 cycles.
  - Raise `enable`: frame sent.
  - Drop `enable` in the middle of the data bits: the frame completes, and no second pop occurs despite remaining data.
- Reset mid-frame: assert `rst_n` = 0 during data bit 3.
  - `txd` is 1 immediately and `busy` is 0.
  - After release, the next FIFO byte is sent as a complete frame, and the interrupted byte is not resent.
